key_debouncer: RTL and testbench

- Upstream conditioning stage for the pushbutton PIO.
- Takes raw, asynchronous, bouncing key inputs from board pins. Synchronises them to clk, debounces each key independently and normalises polarity.
- Drives a clean, level-stable vector into the PIO's in_port, so the PIO's edge capture sees exactly one edge per physical press or release.

---
 rtl/key_debounce_pkg.sv | 21 ++
 rtl/key_debounce_channel.sv | 88 ++++++++
 rtl/key_debouncer.sv | 74 +++++++
 tb/tb_key_debouncer.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/key_debounce_pkg.sv
// Shared constants and width helpers for the key debouncer.
// No logic; elaboration-time only.
// No flow control.
package key_debounce_pkg;

    // Defaults give a 1 ms sample tick at 50 MHz and a 20 ms stability window.
    localparam int DEF_TICK_DIV     = 50000;
    localparam int DEF_STABLE_TICKS = 20;

    // Bits needed to hold values 0..n-1, never less than one bit so that
    // degenerate settings (n == 1) still produce a legal vector.
    function automatic int width_of(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

    localparam int DEF_CNT_W = width_of(DEF_STABLE_TICKS);
    localparam int DEF_PRE_W = width_of(DEF_TICK_DIV);

endpackage

// File: rtl/key_debounce_channel.sv
// One key channel: 2-flop synchroniser, polarity normalise, stability counter.
// key_db moves on the STABLE_TICKS-th tick seen while input differs from it.
// No backpressure; free-running.
//
// Ports:
//   clk, reset_n  clock, async active-low reset
//   key_raw       raw pin level (asynchronous)
//   tick          shared one-cycle sample strobe from the prescaler
//   key_db        debounced level, 1 = pressed
//   key_busy      sampled input differs from key_db
//   key_press     (KEY_DEBOUNCER_EVENT_EN) one-cycle pulse on key_db rise
//   key_release   (KEY_DEBOUNCER_EVENT_EN) one-cycle pulse on key_db fall
module key_debounce_channel
    import key_debounce_pkg::*;
#(
    parameter int STABLE_TICKS = DEF_STABLE_TICKS,
    parameter bit ACTIVE_LOW   = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic key_raw,
    input  logic tick,
    output logic key_db,
    output logic key_busy
`ifdef KEY_DEBOUNCER_EVENT_EN
    ,
    output logic key_press,
    output logic key_release
`endif
);

    localparam int               CNT_W    = width_of(STABLE_TICKS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);

    logic             sync1;
    logic             sync2;
    logic             key_sync;
    logic [CNT_W-1:0] cnt;
    logic             done;

    // Synchroniser resets to the released pin level so no spurious press
    // is seen right after reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= ACTIVE_LOW;
            sync2 <= ACTIVE_LOW;
        end else begin
            sync1 <= key_raw;
            sync2 <= sync1;
        end
    end

    assign key_sync = sync2 ^ ACTIVE_LOW;
    assign key_busy = key_sync ^ key_db;

    // Final tick of the stability window while still differing.
    assign done = key_busy & tick & (cnt == CNT_LAST);

    // Any cycle where the input agrees with key_db clears progress; this is
    // what rejects bounces shorter than the window.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt    <= '0;
            key_db <= 1'b0;
        end else if (!key_busy) begin
            cnt <= '0;
        end else if (done) begin
            cnt    <= '0;
            key_db <= ~key_db;
        end else if (tick) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

`ifdef KEY_DEBOUNCER_EVENT_EN
    // Registered alongside key_db so the pulse lines up with the new level.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            key_press   <= 1'b0;
            key_release <= 1'b0;
        end else begin
            key_press   <= done & ~key_db;
            key_release <= done &  key_db;
        end
    end
`endif

endmodule

// File: rtl/key_debouncer.sv
// Pushbutton conditioner: sync, debounce and polarity-normalise NUM_KEYS keys.
// key_db follows a clean change after 2 sync cycles plus STABLE_TICKS ticks.
// No backpressure; outputs are levels (plus optional one-cycle event pulses).
//
// Ports:
//   clk, reset_n  clock, async active-low reset (deassertion expected to be
//                 synchronous to clk upstream)
//   key_raw       raw pin levels, asynchronous to clk
//   key_db        debounced levels, 1 = pressed (to PIO in_port)
//   key_busy      per-key debounce-in-progress flag
//   key_press     one-cycle rise pulses   (only with KEY_DEBOUNCER_EVENT_EN)
//   key_release   one-cycle fall pulses   (only with KEY_DEBOUNCER_EVENT_EN)
// Optional feature macro: KEY_DEBOUNCER_EVENT_EN
module key_debouncer
    import key_debounce_pkg::*;
#(
    parameter int NUM_KEYS     = 4,
    parameter int TICK_DIV     = DEF_TICK_DIV,
    parameter int STABLE_TICKS = DEF_STABLE_TICKS,
    parameter int ACTIVE_LOW   = 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [NUM_KEYS-1:0] key_raw,
    output logic [NUM_KEYS-1:0] key_db,
    output logic [NUM_KEYS-1:0] key_busy
`ifdef KEY_DEBOUNCER_EVENT_EN
    ,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release
`endif
);

    localparam int               PRE_W    = width_of(TICK_DIV);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
    localparam bit               INVERT   = (ACTIVE_LOW != 0);

    logic [PRE_W-1:0] pre_cnt;
    logic             tick;

    // Shared free-running prescaler; with TICK_DIV == 1 it sits at 0 and
    // tick is high every cycle.
    assign tick = (pre_cnt == PRE_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pre_cnt <= '0;
        end else if (tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + PRE_W'(1);
        end
    end

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_chan
        key_debounce_channel #(
            .STABLE_TICKS (STABLE_TICKS),
            .ACTIVE_LOW   (INVERT)
        ) u_chan (
            .clk         (clk),
            .reset_n     (reset_n),
            .key_raw     (key_raw[i]),
            .tick        (tick),
            .key_db      (key_db[i]),
            .key_busy    (key_busy[i])
`ifdef KEY_DEBOUNCER_EVENT_EN
            ,
            .key_press   (key_press[i]),
            .key_release (key_release[i])
`endif
        );
    end

endmodule

// File: tb/tb_key_debouncer.sv
// Bench for key_debouncer with TICK_DIV=4, STABLE_TICKS=3, ACTIVE_LOW=1.
// Stimulus pushes expected key_db transitions (and event pulses) with the
// edge count at which they must appear; a monitor checks them on change.
module tb_key_debouncer;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] key_raw;
    logic [3:0] key_db;
    logic [3:0] key_busy;
`ifdef KEY_DEBOUNCER_EVENT_EN
    logic [3:0] key_press;
    logic [3:0] key_release;
`endif

    key_debouncer #(
        .NUM_KEYS     (4),
        .TICK_DIV     (4),
        .STABLE_TICKS (3),
        .ACTIVE_LOW   (1)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .key_raw     (key_raw),
        .key_db      (key_db),
        .key_busy    (key_busy)
`ifdef KEY_DEBOUNCER_EVENT_EN
        ,
        .key_press   (key_press),
        .key_release (key_release)
`endif
    );

    always #5 clk = ~clk;

    // Posedges since last reset release; at a negedge ec == e after edge e.
    int ec;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) ec <= 0;
        else          ec <= ec + 1;
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (ec=%0d)", name, act, exp, ec);
    endtask

    typedef struct {
        int         at;
        logic [3:0] db;
    } db_exp_t;
    db_exp_t db_q[$];

    typedef struct {
        int         at;
        logic [3:0] press;
        logic [3:0] release_;
    } ev_exp_t;
    ev_exp_t ev_q[$];

    task automatic expect_db(input int at, input logic [3:0] db,
                             input logic [3:0] press, input logic [3:0] rel);
        db_exp_t d;
        ev_exp_t e;
        d.at = at; d.db = db;
        db_q.push_back(d);
        e.at = at; e.press = press; e.release_ = rel;
        ev_q.push_back(e);
    endtask

    // Monitor: any key_db change or event pulse must match the queue head.
    logic [3:0] prev_db = 4'h0;
    always @(negedge clk) begin
        db_exp_t d;
        if (reset_n && key_db !== prev_db) begin
            if (db_q.size() == 0) begin
                check("unexpected key_db change", {28'h0, key_db}, {28'h0, prev_db});
            end else begin
                d = db_q.pop_front();
                check("key_db value", {28'h0, key_db}, {28'h0, d.db});
                check("key_db edge", ec, d.at);
            end
        end
        prev_db = key_db;
`ifdef KEY_DEBOUNCER_EVENT_EN
        if ((key_press | key_release) != 4'h0) begin
            ev_exp_t e;
            if (ev_q.size() == 0) begin
                check("unexpected event", {24'h0, key_press, key_release}, 32'h0);
            end else begin
                e = ev_q.pop_front();
                check("key_press", {28'h0, key_press}, {28'h0, e.press});
                check("key_release", {28'h0, key_release}, {28'h0, e.release_});
                check("event edge", ec, e.at);
            end
        end
`endif
    end

    task automatic wait_ec(input int n);
        int guard;
        guard = 0;
        while (ec != n && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        if (ec != n) check("wait timeout", ec, n);
    endtask

    initial begin
        reset_n = 1'b0;
        key_raw = 4'hF;
        repeat (3) @(negedge clk);
        check("reset key_db", {28'h0, key_db}, 32'h0);
        check("reset key_busy", {28'h0, key_busy}, 32'h0);
`ifdef KEY_DEBOUNCER_EVENT_EN
        check("reset events", {24'h0, key_press, key_release}, 32'h0);
`endif
        reset_n = 1'b1;

        // Idle released keys: nothing may move for 100 cycles.
        wait_ec(50);
        check("idle key_busy", {28'h0, key_busy}, 32'h0);
        wait_ec(100);
        check("idle key_db", {28'h0, key_db}, 32'h0);

        // Press key 0: raw captured at edge 101, sync after 102, ticks at
        // 104/108/112 -> key_db rises at edge 112.
        key_raw = 4'hE;
        expect_db(112, 4'h1, 4'h1, 4'h0);
        wait_ec(101);
        check("busy before sync", {28'h0, key_busy}, 32'h0);
        wait_ec(102);
        check("busy after sync", {28'h0, key_busy}, 32'h1);
        wait_ec(113);
        check("busy cleared after press", {28'h0, key_busy}, 32'h0);
        check("key_db after press", {28'h0, key_db}, 32'h1);

        // Bounce key 1 every 5 cycles: at most 2 ticks per phase, never 3.
        for (int k = 0; k < 40; k++) begin
            wait_ec(120 + 5 * k);
            key_raw = (k % 2 == 0) ? 4'hC : 4'hE;
            wait_ec(122 + 5 * k);
            check("bounce key_busy", {28'h0, key_busy}, (k % 2 == 0) ? 32'h2 : 32'h0);
        end
        wait_ec(320);
        check("key_db after bounce", {28'h0, key_db}, 32'h1);

        // Release key 0: capture 331, sync 332, ticks 336/340/344.
        wait_ec(330);
        key_raw = 4'hF;
        expect_db(344, 4'h0, 4'h0, 4'h1);
        wait_ec(333);
        check("busy during release", {28'h0, key_busy}, 32'h1);
        wait_ec(345);
        check("key_db after release", {28'h0, key_db}, 32'h0);
        check("busy after release", {28'h0, key_busy}, 32'h0);

        // Keys 2 and 3 together: capture 361, ticks 364/368/372.
        wait_ec(360);
        key_raw = 4'h3;
        expect_db(372, 4'hC, 4'hC, 4'h0);
        wait_ec(373);
        check("key_db dual press", {28'h0, key_db}, 32'hC);

        wait_ec(380);
        key_raw = 4'hF;
        expect_db(392, 4'h0, 4'h0, 4'hC);

        // Reset after two ticks of progress on key 0 (ticks 404, 408).
        wait_ec(400);
        key_raw = 4'hE;
        wait_ec(404);
        check("busy before mid reset", {28'h0, key_busy}, 32'h1);
        wait_ec(410);
        reset_n = 1'b0;
        #1;
        check("key_db in mid reset", {28'h0, key_db}, 32'h0);
        check("key_busy in mid reset", {28'h0, key_busy}, 32'h0);
        repeat (3) @(negedge clk);
        // After release: capture edge 1, sync 2, full window at ticks 4/8/12.
        expect_db(12, 4'h1, 4'h1, 4'h0);
        reset_n = 1'b1;
        wait_ec(11);
        check("key_db before full window", {28'h0, key_db}, 32'h0);
        wait_ec(13);
        check("key_db after full window", {28'h0, key_db}, 32'h1);

        wait_ec(30);
        check("pending key_db expectations", db_q.size(), 0);
`ifdef KEY_DEBOUNCER_EVENT_EN
        check("pending event expectations", ev_q.size(), 0);
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1);
    end

endmodule
